sdram_port_arbiter: RTL and testbench

//   Multi-port front end for the SDRAM engines: grants NUM_PORTS clients round-robin access, one

---
 rtl/sdram_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin front end for the SDRAM command engine: serialises client accesses to one
// operation at a time and slips an auto-refresh in ahead of clients at a fixed period.
module sdram_port_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 64,
    parameter int REFRESH_CYCLES = 780
) (
    input  logic                        iclk,
    input  logic                        ireset,
    input  logic                        iinit_done,
    input  logic [NUM_PORTS-1:0]        ireq,
    input  logic [NUM_PORTS-1:0]        iwe,
    input  logic [NUM_PORTS*ADDR_W-1:0] iaddr,
    input  logic [NUM_PORTS*DATA_W-1:0] iwdata,
    output logic [NUM_PORTS-1:0]        oack,
    output logic [DATA_W-1:0]           ordata,
    output logic [NUM_PORTS-1:0]        ogrant,
    output logic                        obusy,
    output logic                        orefresh_miss,
    output logic                        ocmd_req,
    output logic                        ocmd_we,
    output logic                        ocmd_refresh,
    output logic [ADDR_W-1:0]           ocmd_addr,
    output logic [DATA_W-1:0]           ocmd_wdata,
    input  logic                        icmd_fin,
    input  logic [DATA_W-1:0]           icmd_rdata
);

    localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [PIDX_W-1:0]    PTR_RESET  = PIDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] PORT0_HOT  = NUM_PORTS'(1);

    // state     | meaning
    // INIT_WAIT | back end not initialised, no grants
    // IDLE      | arbitrate refresh vs clients
    // ISSUE     | one-cycle command start pulse
    // WAIT_FIN  | back end executing, waiting for icmd_fin
    // ACK       | completion pulse to the served client
    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_FIN,
        S_ACK
    } state_t;

    state_t                 state_q;
    logic [PIDX_W-1:0]      ptr_q;
    logic [CNT_W-1:0]       ref_cnt_q, ref_cnt_d;
    logic                   ref_pend_q, ref_pend_d;
    logic                   miss_q, miss_d;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [NUM_PORTS-1:0]   ack_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   busy_q;
    logic                   cmd_req_q;
    logic                   cmd_we_q;
    logic                   cmd_ref_q;
    logic [ADDR_W-1:0]      cmd_addr_q;
    logic [DATA_W-1:0]      cmd_wdata_q;

    logic                   expire;
    logic                   take_ref;
    logic                   pick_found;
    logic [PIDX_W-1:0]      pick_idx;
    logic [PIDX_W-1:0]      scan_idx;
    int                     scan_pos;

    logic [ADDR_W-1:0]      addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0]      wdata_arr [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_arr[p]  = iaddr[p*ADDR_W +: ADDR_W];
        assign wdata_arr[p] = iwdata[p*DATA_W +: DATA_W];
    end

    // Scan starts one past the last granted port so every requester is reached within NUM_PORTS grants.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_pos   = 0;
        scan_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            scan_pos = int'(ptr_q) + i;
            if (scan_pos >= NUM_PORTS) begin
                scan_pos = scan_pos - NUM_PORTS;
            end
            scan_idx = PIDX_W'(scan_pos);
            if (!pick_found && ireq[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // An expiry seen in IDLE is served the same cycle, so it beats any client request.
    always_comb begin
        expire    = iinit_done && (ref_cnt_q == '0);
        take_ref  = (state_q == S_IDLE) && (ref_pend_q || expire);
        ref_cnt_d = ref_cnt_q;
        if (iinit_done) begin
            ref_cnt_d = expire ? CNT_RELOAD : ref_cnt_q - 1'b1;
        end
        ref_pend_d = ref_pend_q;
        if (take_ref) begin
            ref_pend_d = expire && ref_pend_q;
        end else if (expire) begin
            ref_pend_d = 1'b1;
        end
        miss_d = miss_q || (expire && ref_pend_q);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q     <= S_INIT_WAIT;
            ptr_q       <= PTR_RESET;
            ref_cnt_q   <= CNT_RELOAD;
            ref_pend_q  <= 1'b0;
            miss_q      <= 1'b0;
            grant_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            cmd_req_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_ref_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            miss_q     <= miss_d;
            ack_q      <= '0;
            cmd_req_q  <= 1'b0;
            case (state_q)
                S_INIT_WAIT: begin
                    if (iinit_done) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (take_ref) begin
                        state_q   <= S_ISSUE;
                        cmd_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cmd_ref_q <= 1'b1;
                        cmd_we_q  <= 1'b0;
                        grant_q   <= '0;
                    end else if (pick_found) begin
                        state_q     <= S_ISSUE;
                        cmd_req_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_ref_q   <= 1'b0;
                        cmd_we_q    <= iwe[pick_idx];
                        cmd_addr_q  <= addr_arr[pick_idx];
                        cmd_wdata_q <= wdata_arr[pick_idx];
                        grant_q     <= PORT0_HOT << pick_idx;
                        ptr_q       <= pick_idx;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_FIN;
                end
                S_WAIT_FIN: begin
                    if (icmd_fin) begin
                        state_q <= S_ACK;
                        if (!cmd_ref_q) begin
                            ack_q <= grant_q;
                            if (!cmd_we_q) begin
                                rdata_q <= icmd_rdata;
                            end
                        end
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_INIT_WAIT;
                end
            endcase
        end
    end

    assign oack          = ack_q;
    assign ordata        = rdata_q;
    assign ogrant        = grant_q;
    assign obusy         = busy_q;
    assign orefresh_miss = miss_q;
    assign ocmd_req      = cmd_req_q;
    assign ocmd_we       = cmd_we_q;
    assign ocmd_refresh  = cmd_ref_q;
    assign ocmd_addr     = cmd_addr_q;
    assign ocmd_wdata    = cmd_wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level reference model of the arbiter.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 64;
    localparam int RC = 16;

    logic              iclk = 1'b0;
    logic              ireset, iinit_done;
    logic [NP-1:0]     ireq, iwe;
    logic [NP*AW-1:0]  iaddr;
    logic [NP*DW-1:0]  iwdata;
    logic [NP-1:0]     oack, ogrant;
    logic [DW-1:0]     ordata, ocmd_wdata, icmd_rdata;
    logic              obusy, orefresh_miss, ocmd_req, ocmd_we, ocmd_refresh, icmd_fin;
    logic [AW-1:0]     ocmd_addr;

    always #5 iclk = ~iclk;

    sdram_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .REFRESH_CYCLES(RC)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iinit_done(iinit_done),
        .ireq(ireq), .iwe(iwe), .iaddr(iaddr), .iwdata(iwdata),
        .oack(oack), .ordata(ordata), .ogrant(ogrant), .obusy(obusy),
        .orefresh_miss(orefresh_miss), .ocmd_req(ocmd_req), .ocmd_we(ocmd_we),
        .ocmd_refresh(ocmd_refresh), .ocmd_addr(ocmd_addr), .ocmd_wdata(ocmd_wdata),
        .icmd_fin(icmd_fin), .icmd_rdata(icmd_rdata)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // reference model: one operation record plus refresh bookkeeping
    bit            m_live, m_active, m_ref, m_pend, m_miss, m_we;
    int            m_run, m_issue, m_finc, m_ptr, m_gidx;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    // back-end / client stimulus controls
    int  fin_at = -1;
    int  fin_delay = 3;
    bit  hold = 0, spur_en = 0, fin_rand = 0, fixed_rdata = 0, auto_drop = 0;
    int  n_req_seen = 0;
    int  gq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic model_edge();
        bit expire, take_ref, pend_old;
        int idx, c;
        if (ireset) begin
            m_live = 0; m_active = 0; m_ref = 0; m_pend = 0; m_miss = 0; m_we = 0;
            m_run = 0; m_issue = -10; m_finc = -1; m_ptr = NP - 1; m_gidx = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            return;
        end
        pend_old = m_pend;
        expire   = iinit_done && ((m_run % RC) == RC - 1);
        take_ref = m_live && !m_active && (m_pend || expire);
        if (expire && pend_old) m_miss = 1;
        if (iinit_done) m_run++;
        if (take_ref) m_pend = expire && pend_old;
        else if (expire) m_pend = 1;

        if (!m_live) begin
            m_live = iinit_done;
        end else if (!m_active) begin
            if (take_ref) begin
                m_active = 1; m_ref = 1; m_we = 0; m_issue = cyc + 1; m_finc = -1;
            end else begin
                idx = -1;
                for (int k = 1; k <= NP; k++) begin
                    c = (m_ptr + k) % NP;
                    if (idx < 0 && ireq[c]) idx = c;
                end
                if (idx >= 0) begin
                    m_active = 1; m_ref = 0; m_gidx = idx; m_ptr = idx;
                    m_we = iwe[idx];
                    m_addr = iaddr[idx*AW +: AW];
                    m_wdata = iwdata[idx*DW +: DW];
                    m_issue = cyc + 1; m_finc = -1;
                end
            end
        end else if (cyc == m_issue) begin
            // the start-pulse cycle ignores completion
        end else if (m_finc < 0) begin
            if (icmd_fin) begin
                m_finc = cyc;
                if (!m_ref && !m_we) m_rdata = icmd_rdata;
            end
        end else begin
            m_active = 0;
        end
    endtask

    task automatic check_all();
        logic [NP-1:0] hot, e_grant, e_ack;
        hot = '0;
        hot[m_gidx] = 1'b1;
        e_grant = (m_active && !m_ref) ? hot : '0;
        e_ack   = (m_active && !m_ref && m_finc >= 0 && cyc == m_finc + 1) ? hot : '0;
        chk("ogrant", 64'(ogrant), 64'(e_grant));
        chk("oack", 64'(oack), 64'(e_ack));
        chk("obusy", 64'(obusy), 64'(m_active));
        chk("ocmd_req", 64'(ocmd_req), 64'(m_active && cyc == m_issue));
        chk("ocmd_refresh", 64'(ocmd_refresh), 64'(m_ref));
        chk("ocmd_we", 64'(ocmd_we), 64'(m_we));
        chk("ocmd_addr", 64'(ocmd_addr), 64'(m_addr));
        chk("ocmd_wdata", ocmd_wdata, m_wdata);
        chk("ordata", ordata, m_rdata);
        chk("orefresh_miss", 64'(orefresh_miss), 64'(m_miss));
    endtask

    task automatic step();
        bit waiting;
        waiting  = m_active && (cyc != m_issue) && (m_finc < 0);
        icmd_fin = !hold && (cyc == fin_at);
        if (!icmd_fin && spur_en && !waiting && $urandom_range(0, 9) == 0) icmd_fin = 1'b1;
        if (!fixed_rdata) icmd_rdata = {$urandom, $urandom};
        model_edge();
        @(posedge iclk);
        #1;
        cyc++;
        check_all();
        if (ireset) begin
            fin_at = -1;
        end else if (ocmd_req) begin
            n_req_seen++;
            if (fin_rand) fin_delay = $urandom_range(1, 4);
            fin_at = cyc + fin_delay;
            if (!ocmd_refresh) begin
                for (int p = 0; p < NP; p++) if (ogrant[p]) gq.push_back(p);
            end
        end
        if (auto_drop) ireq = ireq & ~oack;
    endtask

    task automatic rand_clients();
        for (int p = 0; p < NP; p++) begin
            if (oack[p]) ireq[p] = 1'b0;
            else if (!ireq[p] && $urandom_range(0, 3) == 0) ireq[p] = 1'b1;
            iwe[p] = 1'($urandom);
            iaddr[p*AW +: AW] = AW'($urandom);
            iwdata[p*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        ireset = 1; iinit_done = 0; ireq = '0; iwe = '0; iaddr = '0; iwdata = '0;
        icmd_fin = 0; icmd_rdata = '0;
        for (int p = 0; p < NP; p++) begin
            iaddr[p*AW +: AW] = AW'(22'h10_0000 + p * 22'h111);
            iwdata[p*DW +: DW] = {32'hA5A5_0000 + p, 32'h5A5A_0000 + p};
        end
        step(); step();

        // 1: no grant before init, then request -> start pulse two cycles after init
        ireset = 0; ireq = 4'b0001;
        iaddr[0 +: AW] = 22'h2A_5A5A;
        n_req_seen = 0;
        repeat (50) step();
        chk("t1_quiet_before_init", 64'(n_req_seen), 64'd0);
        gq.delete();
        iinit_done = 1;
        step();
        chk("t1_req_after_1", 64'(ocmd_req), 64'd0);
        step();
        chk("t1_req_after_2", 64'(ocmd_req), 64'd1);
        chk("t1_addr_port0", 64'(ocmd_addr), 64'h2A_5A5A);

        // 2: all ports continuously -> 0,1,2,3,0
        ireq = 4'hF;
        for (b = 0; b < 200 && gq.size() < 5; b++) step();
        chk("t2_timeout", 64'(gq.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("t2_order", 64'(gq[i]), 64'(i % NP));

        // 3: read data return and write latching
        ireq = '0; auto_drop = 1;
        for (b = 0; b < 50 && m_active; b++) step();
        iwe[2] = 0; iaddr[2*AW +: AW] = 22'h00_1234;
        fixed_rdata = 1; icmd_rdata = 64'hDEAD_BEEF_0123_4567;
        ireq = 4'b0100;
        for (b = 0; b < 50 && !oack[2]; b++) step();
        chk("t3_read_ack_seen", 64'(b < 50), 64'd1);
        chk("t3_ordata", ordata, 64'hDEAD_BEEF_0123_4567);
        fixed_rdata = 0;
        iwe[1] = 1; iaddr[1*AW +: AW] = 22'h3F_0F0F; iwdata[1*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        ireq = 4'b0010;
        for (b = 0; b < 50 && !(ocmd_req && !ocmd_refresh && ogrant[1]); b++) step();
        chk("t3_write_issued", 64'(b < 50), 64'd1);
        chk("t3_write_we", 64'(ocmd_we), 64'd1);
        chk("t3_write_wdata", ocmd_wdata, 64'h0123_4567_89AB_CDEF);
        chk("t3_write_addr", 64'(ocmd_addr), 64'h3F_0F0F);
        iwdata[1*DW +: DW] = 64'hFFFF_0000_FFFF_0000;
        for (b = 0; b < 50 && !oack[1]; b++) step();
        chk("t3_write_held", ocmd_wdata, 64'h0123_4567_89AB_CDEF);

        // 4: request arriving with refresh expiry -> refresh first, then port 0
        ireq = '0;
        for (b = 0; b < 100 && !(m_live && !m_active && !m_pend && (m_run % RC) == RC - 1); b++) step();
        chk("t4_align", 64'(b < 100), 64'd1);
        ireq = 4'b0001;
        step();
        for (b = 0; b < 20 && !ocmd_req; b++) step();
        chk("t4_first_refresh", 64'(ocmd_refresh), 64'd1);
        chk("t4_refresh_no_grant", 64'(ogrant), 64'd0);
        step();
        for (b = 0; b < 20 && !ocmd_req; b++) step();
        chk("t4_then_port0", 64'(ogrant), 64'b0001);
        chk("t4_then_not_refresh", 64'(ocmd_refresh), 64'd0);
        for (b = 0; b < 20 && !oack[0]; b++) step();

        // 5: stalled back end -> sticky refresh miss
        hold = 1; ireq = 4'b0001;
        for (b = 0; b < 50 && !ocmd_req; b++) step();
        repeat (40) step();
        chk("t5_miss_set", 64'(orefresh_miss), 64'd1);
        hold = 0; fin_at = cyc;
        repeat (30) step();
        chk("t5_miss_sticky", 64'(orefresh_miss), 64'd1);

        // 6: reset while waiting for completion
        fin_delay = 5; ireq = 4'b0001;
        for (b = 0; b < 50 && !(m_active && !m_ref && cyc > m_issue && m_finc < 0); b++) step();
        chk("t6_in_wait", 64'(obusy), 64'd1);
        ireset = 1;
        step();
        chk("t6_ack", 64'(oack), 64'd0);
        chk("t6_busy", 64'(obusy), 64'd0);
        chk("t6_grant", 64'(ogrant), 64'd0);
        chk("t6_miss", 64'(orefresh_miss), 64'd0);
        chk("t6_req", 64'(ocmd_req), 64'd0);
        ireset = 0; iinit_done = 0; ireq = 4'b1001;
        n_req_seen = 0;
        repeat (5) step();
        chk("t6_quiet_init", 64'(n_req_seen), 64'd0);
        iinit_done = 1;
        step(); step();
        chk("t6_port0_first", 64'(ogrant), 64'b0001);

        // random traffic with jittered completion and stray fin pulses
        fin_delay = 3; fin_rand = 1; spur_en = 1;
        repeat (800) begin
            rand_clients();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
